single_game_ctrl: RTL and testbench
===================================

Name: single_game_ctrl

Overview:
Game-flow controller for single-player pong; sits directly upstream of the pixel/ball-graphics stage.
- Consumes that stage's hit/miss pulses plus a frame tick and start button.
- Produces the score, balls-remaining count and random vector the graphics stage reads.
- Produces a hold signal that freezes play between serves, and the overall game state.

Parameters:
MAX_BALLS, 3, balls per game (1..3, fits 2-bit ball output)
WIN_SCORE, 12, score at which game ends (1..15)
SERVE_TICKS, 120, frame ticks of pause after a miss and minimum OVER dwell
LFSR_SEED, 16'hACE1, nonzero LFSR reset/reload value

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_btn  in  1  raw start button, asynchronous
frame_tick  in  1  one-clk pulse per video frame
hit  in  1  paddle-hit indication from graphics stage (may be multi-cycle level)
miss  in  1  miss indication from graphics stage (may be multi-cycle level)
score  out  4  current score
ball  out  2  balls remaining
rng  out  16  free-running pseudo-random vector
state  out  2  0=IDLE 1=PLAY 2=SERVE 3=OVER
hold  out  1  1 = graphics stage must freeze ball motion
high_score  out  4  best score (only with HIGH_SCORE_EN)

Behaviour:
Reset values:
- state=IDLE, score=0, ball=MAX_BALLS, hold=1, rng=LFSR_SEED, timer=0, high_score=0.
- All edge-detect and synchronizer flops = 0.

Input conditioning:
- start_btn passes through a 2-flop synchronizer; start_rise = synced & ~synced_d.
- hit_rise = hit & ~hit_d; miss_rise = miss & ~miss_d.
- Only rising edges act. A level held many cycles counts once.

LFSR:
- 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, steps every clk in all states.
- If the value ever equals 0, reload LFSR_SEED next cycle.
- rng is the register output directly.

Timer:
- 8-bit down-counter, decrements on frame_tick when nonzero.
- Loaded with SERVE_TICKS on entry to SERVE or OVER.

FSM (all transitions registered, one clk):
- IDLE:
  - hold=1; score held 0, ball held MAX_BALLS.
  - start_rise -> PLAY.
- PLAY:
  - hold=0.
  - miss_rise: ball <= ball-1. If old ball==1 -> OVER (ball=0), else -> SERVE.
  - else hit_rise: score <= score+1, saturating at 15. If score+1 >= WIN_SCORE -> OVER.
  - Simultaneous hit_rise and miss_rise in the same clk: miss wins, hit discarded.
- SERVE:
  - hold=1; hit/miss ignored.
  - timer==0 -> PLAY.
- OVER:
  - hold=1; hit/miss ignored.
  - start_rise while timer==0 -> IDLE, which clears score and restores ball on that transition.
  - start_rise while timer!=0 is ignored.
- state encoding 3 is terminal until start.

Other rules:
- frame_tick and hit/miss edges in the same clk are both honoured; the timer is not loaded until the state changes.
- Async rst in any state forces reset values immediately; no partial score update survives.
- Score and ball change only on the clk after the qualifying edge (latency 1).

Optional Feature:
HIGH_SCORE_EN
- Defined:
  - high_score register updates on entry to OVER if score > high_score.
  - It is not cleared by IDLE, only by rst.
- Undefined:
  - high_score port still exists and is tied to 4'd0; no register is inferred.

Test Plan:
1. rst, then start_btn high 3 clks -> state 0->1 after sync (≤3 clks); score=0, ball=3, hold=0.
2. In PLAY, hit held high 10 clks -> score increments exactly once to 1; 12 separate hit pulses -> score=12, state=OVER, hold=1.
3. In PLAY with ball=3, miss pulse -> ball=2, state=SERVE, hold=1. After 120 frame_ticks -> state=PLAY. Hit during SERVE leaves score unchanged.
4. hit and miss rise in same clk with score=5, ball=2 -> score stays 5, ball=1, state=SERVE.
5. Third miss -> ball=0, state=OVER. start_rise before 120 ticks ignored; start_rise after -> IDLE with score=0, ball=3.
6. Force LFSR state 0 via rst-free injection / check rng never 0 over 70000 clks. With HIGH_SCORE_EN, game ending at score 7 then a game at 4 -> high_score=7.

Source files
------------

// File: rtl/single_game_ctrl_if.sv
// single_game_ctrl_if: groups the game controller's stimulus inputs and its
// game-state outputs. The controller uses the slave modport and the driving
// side uses the master modport.
interface single_game_ctrl_if;
  logic        start_btn;
  logic        frame_tick;
  logic        hit;
  logic        miss;
  logic [3:0]  score;
  logic [1:0]  ball;
  logic [15:0] rng;
  logic [1:0]  state;
  logic        hold;
  logic [3:0]  high_score;

  modport master (
    output start_btn, frame_tick, hit, miss,
    input  score, ball, rng, state, hold, high_score
  );

  modport slave (
    input  start_btn, frame_tick, hit, miss,
    output score, ball, rng, state, hold, high_score
  );
endinterface

// File: rtl/single_game_ctrl.sv
// single_game_ctrl: game-flow controller for single-player pong.
// It tracks the score, the balls remaining and the serve/game-over pauses,
// and it runs a free-running 16-bit Galois LFSR for the graphics stage.
// Optional feature macro: HIGH_SCORE_EN. When this macro is defined, a
// best-score register is kept. When it is undefined, high_score is tied to 0.
module single_game_ctrl #(
  parameter int          MAX_BALLS   = 3,
  parameter int          WIN_SCORE   = 12,
  parameter int          SERVE_TICKS = 120,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic               clk,
  input logic               rst,
  single_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_SERVE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [1:0]  BALLS_INIT = 2'(MAX_BALLS);
  localparam logic [4:0]  WIN_LIMIT  = 5'(WIN_SCORE);
  localparam logic [7:0]  TIMER_INIT = 8'(SERVE_TICKS);
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;  // x^16+x^14+x^13+x^11+1

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_score;
  logic [3:0]  w_score_next;
  logic [1:0]  r_ball;
  logic [1:0]  w_ball_next;
  logic [7:0]  r_timer;
  logic [7:0]  w_timer_next;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic        w_hold;

  logic        r_start_meta;
  logic        r_start_sync;
  logic        r_start_d;
  logic        r_hit_d;
  logic        r_miss_d;

  logic        w_start_rise;
  logic        w_hit_rise;
  logic        w_miss_rise;
  logic [4:0]  w_score_inc;
  logic        w_enter_wait;

  // Only rising edges act, so a level held for many cycles counts once.
  assign w_start_rise = r_start_sync & ~r_start_d;
  assign w_hit_rise   = bus.hit & ~r_hit_d;
  assign w_miss_rise  = bus.miss & ~r_miss_d;
  assign w_score_inc  = {1'b0, r_score} + 5'd1;

  // Synchronize the raw start button and keep delayed copies for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_meta <= 1'b0;
      r_start_sync <= 1'b0;
      r_start_d    <= 1'b0;
      r_hit_d      <= 1'b0;
      r_miss_d     <= 1'b0;
    end else begin
      r_start_meta <= bus.start_btn;
      r_start_sync <= r_start_meta;
      r_start_d    <= r_start_sync;
      r_hit_d      <= bus.hit;
      r_miss_d     <= bus.miss;
    end
  end

  // Galois LFSR step. The state cannot normally reach zero, but if it does
  // (for example after an upset), the register is reloaded with the seed.
  always_comb begin
    w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    if (r_lfsr == 16'h0000) begin
      w_lfsr_next = LFSR_SEED;
    end
  end

  // LFSR register, which runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Game FSM: next-state, score/ball updates and the hold output.
  always_comb begin
    w_state_next = r_state;
    w_score_next = r_score;
    w_ball_next  = r_ball;
    w_hold       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_score_next = 4'd0;
        w_ball_next  = BALLS_INIT;
        if (w_start_rise) begin
          w_state_next = S_PLAY;
        end
      end
      S_PLAY: begin
        w_hold = 1'b0;
        // A miss takes priority over a hit that arrives in the same cycle.
        if (w_miss_rise) begin
          w_ball_next  = r_ball - 2'd1;
          w_state_next = (r_ball == 2'd1) ? S_OVER : S_SERVE;
        end else if (w_hit_rise) begin
          w_score_next = w_score_inc[4] ? 4'hF : w_score_inc[3:0];
          if (w_score_inc >= WIN_LIMIT) begin
            w_state_next = S_OVER;
          end
        end
      end
      S_SERVE: begin
        if (r_timer == 8'd0) begin
          w_state_next = S_PLAY;
        end
      end
      S_OVER: begin
        if (w_start_rise && (r_timer == 8'd0)) begin
          w_state_next = S_IDLE;
          w_score_next = 4'd0;
          w_ball_next  = BALLS_INIT;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Pause timer: it is loaded when the FSM enters SERVE or OVER, and otherwise counts frames down to zero.
  always_comb begin
    w_enter_wait = (w_state_next != r_state) &&
                   ((w_state_next == S_SERVE) || (w_state_next == S_OVER));
    w_timer_next = r_timer;
    if (w_enter_wait) begin
      w_timer_next = TIMER_INIT;
    end else if (bus.frame_tick && (r_timer != 8'd0)) begin
      w_timer_next = r_timer - 8'd1;
    end
  end

  // FSM state, score, ball and timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_score <= 4'd0;
      r_ball  <= BALLS_INIT;
      r_timer <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_score <= w_score_next;
      r_ball  <= w_ball_next;
      r_timer <= w_timer_next;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [3:0] r_high_score;

  // Capture the best score on entry to OVER. Returning to IDLE does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_score <= 4'd0;
    end else if ((w_state_next == S_OVER) && (r_state != S_OVER) &&
                 (w_score_next > r_high_score)) begin
      r_high_score <= w_score_next;
    end
  end

  assign bus.high_score = r_high_score;
`else
  assign bus.high_score = 4'd0;
`endif

  assign bus.score = r_score;
  assign bus.ball  = r_ball;
  assign bus.rng   = r_lfsr;
  assign bus.state = r_state;
  assign bus.hold  = w_hold;

endmodule

// File: tb/tb_single_game_ctrl.sv
// tb_single_game_ctrl: directed self-checking bench for single_game_ctrl.
// A vector table covers start, hit levels and pulses up to a win.
// Hand-written sequences then cover serve pauses, simultaneous edges,
// the game-over dwell, asynchronous reset and the LFSR period.
module tb_single_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

`ifdef HIGH_SCORE_EN
  localparam int EXP_HS = 12;
`else
  localparam int EXP_HS = 0;
`endif

  typedef struct {
    logic       start;
    logic       hit;
    logic       miss;
    logic       tick;
    logic [1:0] e_state;
    logic [3:0] e_score;
    logic [1:0] e_ball;
    logic       e_hold;
  } vec_t;

  vec_t vecs[$];

  single_game_ctrl_if bus();

  single_game_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic h, input logic m, input logic t);
    bus.start_btn  = s;
    bus.hit        = h;
    bus.miss       = m;
    bus.frame_tick = t;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic [3:0] sc,
                         input logic [1:0] b, input logic hd);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".score"}, 32'(bus.score), 32'(sc));
    chk({tag, ".ball"},  32'(bus.ball),  32'(b));
    chk({tag, ".hold"},  32'(bus.hold),  32'(hd));
    $display("%-12s state=%0d score=%0d ball=%0d hold=%0d", tag, bus.state, bus.score, bus.ball, bus.hold);
  endtask

  // Send n one-cycle frame_tick pulses, each followed by one idle cycle.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic start_hold3();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
  endtask

  task automatic start_release();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
  endtask

  task automatic pulse(input logic h, input logic m);
    drive(1'b0, h, m, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  function automatic void add(input logic s, input logic h, input logic m, input logic t,
                              input logic [1:0] st, input logic [3:0] sc,
                              input logic [1:0] b, input logic hd);
    vec_t v;
    v.start = s; v.hit = h; v.miss = m; v.tick = t;
    v.e_state = st; v.e_score = sc; v.e_ball = b; v.e_hold = hd;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] lfsr_exp [6];
    logic [15:0] v0;
    int          cnt;
    int          zeros;

    lfsr_exp = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};

    // Start of game: the start press is seen after synchronization.
    add(1, 0, 0, 0, ST_IDLE, 0, 3, 1);
    add(1, 0, 0, 0, ST_IDLE, 0, 3, 1);
    add(1, 0, 0, 0, ST_PLAY, 0, 3, 0);
    add(0, 0, 0, 0, ST_PLAY, 0, 3, 0);
    // A hit held for 10 cycles counts exactly once.
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, ST_PLAY, 1, 3, 0);
    add(0, 0, 0, 0, ST_PLAY, 1, 3, 0);
    // Eleven more hit pulses reach WIN_SCORE=12, which ends the game.
    for (int k = 1; k <= 11; k++) begin
      add(0, 1, 0, 0, (k < 11) ? ST_PLAY : ST_OVER, 4'(1 + k), 3, (k < 11) ? 1'b0 : 1'b1);
      add(0, 0, 0, 0, (k < 11) ? ST_PLAY : ST_OVER, 4'(1 + k), 3, (k < 11) ? 1'b0 : 1'b1);
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", ST_IDLE, 0, 3, 1);
    chk("reset.rng", 32'(bus.rng), 32'h0000ACE1);
    chk("reset.high_score", 32'(bus.high_score), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("lfsr_step%0d", i), 32'(bus.rng), 32'(lfsr_exp[i]));
    end

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].hit, vecs[i].miss, vecs[i].tick);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_score, vecs[i].e_ball, vecs[i].e_hold);
    end

    // In OVER, a start press before the dwell timer expires is ignored.
    start_hold3();
    start_release();
    chk_out("over_early", ST_OVER, 12, 3, 1);
    chk("over1.high_score", 32'(bus.high_score), 32'(EXP_HS));
    ticks(120);
    chk_out("over_dwell", ST_OVER, 12, 3, 1);
    start_hold3();
    chk_out("over_idle", ST_IDLE, 0, 3, 1);
    chk("idle.high_score", 32'(bus.high_score), 32'(EXP_HS));
    start_release();
    start_hold3();
    chk_out("game2_play", ST_PLAY, 0, 3, 0);
    start_release();

    // A miss enters SERVE. Hits and misses during SERVE are ignored.
    pulse(1'b0, 1'b1);
    chk_out("miss1", ST_SERVE, 0, 2, 1);
    pulse(1'b1, 1'b1);
    chk_out("serve_ign", ST_SERVE, 0, 2, 1);
    ticks(119);
    chk_out("serve_119", ST_SERVE, 0, 2, 1);
    ticks(1);
    chk_out("serve_done", ST_PLAY, 0, 2, 0);

    // With score 5, a hit and a miss in the same cycle: the miss wins.
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    chk_out("score5", ST_PLAY, 5, 2, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk_out("hit_miss", ST_SERVE, 5, 1, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    ticks(120);
    chk_out("serve2_done", ST_PLAY, 5, 1, 0);

    // The last miss ends the game. The OVER dwell blocks early start presses.
    pulse(1'b0, 1'b1);
    chk_out("miss_last", ST_OVER, 5, 0, 1);
    chk("over2.high_score", 32'(bus.high_score), 32'(EXP_HS));
    ticks(60);
    start_hold3();
    start_release();
    chk_out("over2_early", ST_OVER, 5, 0, 1);
    ticks(60);
    start_hold3();
    chk_out("over2_idle", ST_IDLE, 0, 3, 1);
    start_release();

    // Asynchronous reset in the middle of play takes effect without a clock edge.
    start_hold3();
    start_release();
    pulse(1'b1, 1'b0);
    chk_out("pre_rst", ST_PLAY, 1, 3, 0);
    rst = 1'b1;
    #2;
    chk_out("async_rst", ST_IDLE, 0, 3, 1);
    chk("async_rst.rng", 32'(bus.rng), 32'h0000ACE1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // The LFSR has the full 65535-state period and never reaches zero.
    v0    = bus.rng;
    cnt   = 0;
    zeros = 0;
    do begin
      step();
      cnt++;
      if (bus.rng == 16'h0000) zeros++;
    end while ((bus.rng != v0) && (cnt < 70000));
    chk("lfsr_period", 32'(cnt), 32'd65535);
    chk("lfsr_zero_count", 32'(zeros), 32'd0);
    $display("lfsr period=%0d zeros=%0d", cnt, zeros);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
